// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, transmit FSM encodings and the STATUS word packer.
package mmio_uart_tx_pkg;

  localparam logic [31:0] UART_TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] UART_STATUS_OFS = 32'h0000_0004;

  localparam int unsigned STAT_FULL  = 0;
  localparam int unsigned STAT_EMPTY = 1;
  localparam int unsigned STAT_BUSY  = 2;
  localparam int unsigned STAT_OVF   = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  function automatic logic [31:0] pack_status(input logic [7:0] count,
                                              input logic       ovf,
                                              input logic       busy,
                                              input logic       empty,
                                              input logic       full);
    logic [31:0] s;
    s             = '0;
    s[15:8]       = count;
    s[STAT_OVF]   = ovf;
    s[STAT_BUSY]  = busy;
    s[STAT_EMPTY] = empty;
    s[STAT_FULL]  = full;
    return s;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Single-clock TX FIFO with async active-low reset; dout shows the head entry
// combinationally. Pushes when full and pops when empty are ignored.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS decode, sticky overflow,
// registered read data (zero when unselected) and the bit-serial TX FSM.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_wren,
  input  logic [3:0]  mem_wmask,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  output logic        tx,
  output logic        tx_busy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [31:0]   DATA_ADDR = BASE_ADDR + UART_TXDATA_OFS;
  localparam logic [31:0]   STAT_ADDR = BASE_ADDR + UART_STATUS_OFS;

  logic          sel_data, sel_stat;
  logic          push_req, push, pop, clr_ovf;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count, count_d;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          unused_bus_bits;

  assign unused_bus_bits = ^{mem_addr[1:0], mem_wmask[3:1], mem_wdata[31:8]};

  assign sel_data = (mem_addr[31:2] == DATA_ADDR[31:2]);
  assign sel_stat = (mem_addr[31:2] == STAT_ADDR[31:2]);
  assign push_req = mem_wren & sel_data & mem_wmask[0];
  assign push     = push_req & ~fifo_full;
  assign clr_ovf  = mem_wren & sel_stat & mem_wmask[0] & mem_wdata[STAT_OVF];

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rstn),
    .push  (push),
    .din   (mem_wdata[7:0]),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A rejected push and a clear on the same edge leave overflow set.
  always_comb begin
    ovf_d = ovf_q;
    if (push_req && fifo_full) ovf_d = 1'b1;
    else if (clr_ovf)          ovf_d = 1'b0;
  end

  always_comb begin
    rdata_d = '0;
    if (sel_data || sel_stat)
      rdata_d = pack_status(8'(fifo_count), ovf_q, busy_q, fifo_empty, fifo_full);
  end

  // sh_q[0] is always the bit on the line while in DATA; it shifts at each bit end.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_d    = fifo_dout;
          tx_d    = 1'b0;
          baud_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_q == BAUD_LAST) begin
          tx_d    = sh_q[0];
          bit_d   = '0;
          baud_d  = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            sh_d  = {1'b0, sh_q[7:1]};
            tx_d  = sh_q[1];
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    count_d = fifo_count;
    if (push && !pop)      count_d = fifo_count + CW'(1);
    else if (pop && !push) count_d = fifo_count - CW'(1);
  end

  // Busy tracks the post-edge FIFO occupancy and FSM state so it rises with the push.
  assign busy_d = (count_d != '0) | (state_d != ST_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_rdata = rdata_q;
  assign tx        = tx_q;
  assign tx_busy   = busy_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: queue/frame-position reference model, per-cycle
// output comparison, a line receiver, directed literal checks and random traffic.
module tb_mmio_uart_tx;

  localparam int unsigned D     = 4;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wren = 1'b0;
  logic [3:0]  wmask = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] rdata;
  logic        tx;
  logic        tx_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE_ADDR  (BASE),
    .CLK_DIV    (D),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .mem_wren  (wren),
    .mem_wmask (wmask),
    .mem_wdata (wdata),
    .mem_addr  (addr),
    .mem_rdata (rdata),
    .tx        (tx),
    .tx_busy   (tx_busy)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: byte queue, current frame as 10 line levels and a cycle position.
  logic [7:0]  mq[$];
  logic [7:0]  m_sent[$];
  bit          m_inframe = 1'b0;
  int          m_pos = 0;
  logic [9:0]  m_frame = 10'h3FF;
  bit          m_ovf = 1'b0;
  bit          m_busy = 1'b0;
  logic [31:0] m_rdata = 32'h0;

  always @(posedge clk or negedge rstn) begin
    int n;
    bit full, empty, sd, ss, req, clr;
    if (!rstn) begin
      mq.delete();
      m_sent.delete();
      m_inframe = 1'b0;
      m_pos     = 0;
      m_ovf     = 1'b0;
      m_busy    = 1'b0;
      m_rdata   = 32'h0;
    end else begin
      n     = mq.size();
      full  = (n == DEPTH);
      empty = (n == 0);
      sd    = ((addr >> 2) == (BASE >> 2));
      ss    = ((addr >> 2) == ((BASE >> 2) + 1));
      req   = wren && sd && wmask[0];
      clr   = wren && ss && wmask[0] && wdata[3];
      m_rdata = (sd || ss) ? {16'h0, 8'(n), 4'h0, m_ovf, m_busy, empty, full} : 32'h0;
      if (m_inframe) begin
        m_pos++;
        if (m_pos == 10 * D) m_inframe = 1'b0;
      end else if (n > 0) begin
        m_frame = {1'b1, mq[0], 1'b0};
        m_sent.push_back(mq[0]);
        void'(mq.pop_front());
        m_inframe = 1'b1;
        m_pos     = 0;
      end
      if (req && full)  m_ovf = 1'b1;
      else if (clr)     m_ovf = 1'b0;
      if (req && !full) mq.push_back(wdata[7:0]);
      m_busy = (mq.size() != 0) || m_inframe;
    end
  end

  always @(negedge clk) begin
    check("tx", 32'(tx), m_inframe ? 32'(m_frame[m_pos / D]) : 32'h1);
    check("tx_busy", 32'(tx_busy), 32'(m_busy));
    check("mem_rdata", rdata, m_rdata);
  end

  // Line receiver: mid-bit sampling relative to the first low sample.
  bit         rx_on = 1'b0;
  int         rx_i = 0;
  logic [7:0] rx_b = 8'h0;
  logic [7:0] rx_log[$];

  always @(negedge clk) begin
    if (!rstn) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (tx === 1'b0) begin
        rx_on = 1'b1;
        rx_i  = 0;
      end
    end else begin
      rx_i++;
      if (rx_i >= D && rx_i < 9 * D && (rx_i % D) == D / 2) rx_b[(rx_i - D) / D] = tx;
      if (rx_i == 9 * D + D / 2) begin
        check("rx_stop", 32'(tx), 32'h1);
        rx_on = 1'b0;
        rx_log.push_back(rx_b);
        if (m_sent.size() == 0) check("rx_unexpected", 32'(rx_b), 32'hFFFF_FFFF);
        else begin
          check("rx_byte", 32'(rx_b), 32'(m_sent[0]));
          void'(m_sent.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m);
    wren  = we;
    addr  = a;
    wdata = d;
    wmask = m;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    wren  = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    wmask = 4'h0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    idle(1);
    while (tx_busy !== 1'b0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("drain_within_budget", 32'(i < budget), 32'h1);
  endtask

  task automatic check_rx(input string nm, input logic [7:0] exp[$]);
    check({nm, "_count"}, 32'(rx_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < rx_log.size(); i++)
      check(nm, 32'(rx_log[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [9:0] lit41;
    logic [7:0] exp_q[$];
    int r;

    lit41 = 10'b1_01000001_0;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    check("reset_tx", 32'(tx), 32'h1);
    check("reset_busy", 32'(tx_busy), 32'h0);
    check("reset_rdata", rdata, 32'h0);
    drive(1'b0, BASE + 32'h4, 32'h0, 4'h0);
    check("reset_status", rdata, 32'h0000_0002);

    // Single byte 0x41: pinned line pattern and busy window.
    drive(1'b1, BASE, 32'h41, 4'hF);
    check("busy_on_push", 32'(tx_busy), 32'h1);
    for (int k = 1; k <= 41; k++) begin
      idle(1);
      if (k <= 40) check("frame41", 32'(tx), 32'(lit41[(k - 1) / 4]));
      if (k == 40) check("busy_at_40", 32'(tx_busy), 32'h1);
      if (k == 41) check("busy_at_41", 32'(tx_busy), 32'h0);
    end
    idle(3);

    // Fill and overflow behind a frame already on the line.
    rx_log.delete();
    drive(1'b1, BASE, 32'h55, 4'h1);
    for (int i = 0; i < 5; i++) drive(1'b1, BASE, 32'h30 + 32'(i), 4'h1);
    drive(1'b0, BASE + 32'h4, 32'h0, 4'h0);
    check("status_overflow", rdata, 32'h0000_040D);
    drive(1'b1, BASE + 32'h4, 32'h8, 4'h1);
    drive(1'b0, BASE + 32'h4, 32'h0, 4'h0);
    check("status_cleared", rdata, 32'h0000_0405);
    wait_idle(400);
    exp_q = '{8'h55, 8'h30, 8'h31, 8'h32, 8'h33};
    check_rx("fill_rx", exp_q);

    // Pointer wrap: two bursts of three with a drain between.
    rx_log.delete();
    for (int i = 0; i < 3; i++) drive(1'b1, BASE, 32'hA1 + 32'(i), 4'hF);
    wait_idle(300);
    for (int i = 0; i < 3; i++) drive(1'b1, BASE, 32'hB1 + 32'(i), 4'hF);
    wait_idle(300);
    exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3};
    check_rx("wrap_rx", exp_q);

    // Read decode and byte-enable gating.
    drive(1'b0, 32'h1000_0004, 32'h0, 4'h0);
    check("decode_status", rdata, 32'h0000_0002);
    drive(1'b0, 32'h0000_1000, 32'h0, 4'h0);
    check("decode_other", rdata, 32'h0);
    drive(1'b1, BASE, 32'h77, 4'b1110);
    drive(1'b0, BASE + 32'h4, 32'h0, 4'h0);
    check("mask_no_push", rdata, 32'h0000_0002);
    idle(2);
    check("mask_not_busy", 32'(tx_busy), 32'h0);

    // Reset during DATA bit 3.
    rx_log.delete();
    drive(1'b1, BASE, 32'h5A, 4'hF);
    idle(18);
    #2 rstn = 1'b0;
    #1;
    check("midreset_tx", 32'(tx), 32'h1);
    check("midreset_busy", 32'(tx_busy), 32'h0);
    @(negedge clk);
    #1 rstn = 1'b1;
    drive(1'b0, BASE + 32'h4, 32'h0, 4'h0);
    check("midreset_status", rdata, 32'h0000_0002);
    idle(60);
    check("midreset_no_frames", 32'(rx_log.size()), 32'h0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10)      drive(1'b1, BASE, $urandom, 4'hF);
      else if (r < 14) drive(1'b1, BASE, $urandom, 4'($urandom));
      else if (r < 17) drive(1'b1, BASE + 32'h4, $urandom, 4'($urandom));
      else if (r < 25) drive(1'b0, BASE + 32'($urandom_range(0, 7)), 32'h0, 4'h0);
      else if (r < 30) drive(1'($urandom), $urandom, $urandom, 4'($urandom));
      else             idle(1);
    end
    wait_idle(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
